// File: rtl/mem_sweep_pkg.sv
// Shared types for the multi-bank sweep reader: FSM state encoding and width helper.
package mem_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } sweep_state_t;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipeline_sr.sv
// Fixed-depth shift register with synchronous clear; carries side-band tags next to a memory read.
module pipeline_sr #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/sync_fifo_tagged.sv
// Small synchronous FIFO holding data words with their bank/address tags; depth need not be a power of 2.
module sync_fifo_tagged #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/mem_multi_bank_sweep_reader.sv
// Sweeps every (bank, addr) of a multi-bank memory through its registered read port and
// streams each word out with its tags; issue is credit-limited so the buffer never overflows.
module mem_multi_bank_sweep_reader
  import mem_sweep_pkg::*;
#(
  parameter int DATA_WIDTH   = 3,
  parameter int DEPTH        = 3,
  parameter int NUM_BANKS    = 1,
  parameter int BANK_WIDTH   = width_of(NUM_BANKS),
  parameter int READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          done_pulse,
  output logic                          reb,
  output logic [BANK_WIDTH-1:0]         bankb,
  output logic [width_of(DEPTH)-1:0]    addrb,
  input  logic [DATA_WIDTH-1:0]         dob,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [BANK_WIDTH-1:0]         out_bank,
  output logic [width_of(DEPTH)-1:0]    out_addr,
  output logic                          out_last
);

  localparam int ADDR_WIDTH = width_of(DEPTH);
  localparam int BUF_DEPTH  = READ_LATENCY + 2;
  localparam int CW         = $clog2(BUF_DEPTH + 1);

  typedef struct packed {
    logic                  valid;
    logic [BANK_WIDTH-1:0] bank;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  last;
  } tag_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [BANK_WIDTH-1:0] bank;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  last;
  } beat_t;

  sweep_state_t          state_q, state_d;
  logic [BANK_WIDTH-1:0] bank_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         inflight_q;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occupancy;
  logic                  issue_last;
  logic                  push, pop, last_hs;
  tag_t                  tag_in, tag_out;
  beat_t                 beat_in, beat_out;

  assign issue_last = (bank_q == BANK_WIDTH'(NUM_BANKS - 1)) &&
                      (addr_q == ADDR_WIDTH'(DEPTH - 1));
  // A pop in this cycle does not return a credit until the next one.
  assign occupancy  = {1'b0, inflight_q} + {1'b0, fifo_count};

  always_comb begin
    state_d = state_q;
    reb     = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: begin
        reb = (occupancy < (CW+1)'(BUF_DEPTH));
        if (reb && issue_last) state_d = S_DRAIN;
      end
      S_DRAIN: if (last_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bank_q     <= '0;
      addr_q     <= '0;
      inflight_q <= '0;
      done_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_pulse <= last_hs;
      inflight_q <= inflight_q + CW'(reb) - CW'(push);
      if (reb) begin
        if (addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
          addr_q <= '0;
          bank_q <= issue_last ? '0 : bank_q + 1'b1;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end
    end
  end

  assign tag_in = '{valid: reb, bank: bank_q, addr: addr_q, last: issue_last};

  pipeline_sr #(
    .WIDTH ($bits(tag_t)),
    .STAGES(READ_LATENCY)
  ) u_tag_pipe (
    .clk  (clk),
    .reset(reset),
    .d    (tag_in),
    .q    (tag_out)
  );

  assign push    = tag_out.valid;
  assign beat_in = '{data: dob, bank: tag_out.bank, addr: tag_out.addr, last: tag_out.last};

  sync_fifo_tagged #(
    .WIDTH($bits(beat_t)),
    .DEPTH(BUF_DEPTH),
    .CW   (CW)
  ) u_buf (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .din  (beat_in),
    .pop  (pop),
    .dout (beat_out),
    .count(fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign last_hs   = pop && beat_out.last;

  assign busy     = (state_q != S_IDLE);
  assign bankb    = bank_q;
  assign addrb    = addr_q;
  assign out_data = out_valid ? beat_out.data : '0;
  assign out_bank = out_valid ? beat_out.bank : '0;
  assign out_addr = out_valid ? beat_out.addr : '0;
  assign out_last = out_valid && beat_out.last;

endmodule

// File: tb/tb_mem_multi_bank_sweep_reader.sv
// Directed bench: four reader configurations, each fed by a small memory model returning {bank,addr}.
module tb_mem_multi_bank_sweep_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  // A: 2 banks x 3, latency 1
  logic       start_a, busy_a, done_a, reb_a, valid_a, ready_a, last_a;
  logic [0:0] bankb_a, obank_a;
  logic [1:0] addrb_a, oaddr_a;
  logic [2:0] dob_a, data_a;
  // B: 2 banks x 3, latency 2
  logic       start_b, busy_b, done_b, reb_b, valid_b, ready_b, last_b;
  logic [0:0] bankb_b, obank_b;
  logic [1:0] addrb_b, oaddr_b;
  logic [2:0] dob_b, data_b, b_r1;
  // C: 3 banks x 5, latency 1
  logic       start_c, busy_c, done_c, reb_c, valid_c, ready_c, last_c;
  logic [1:0] bankb_c, obank_c;
  logic [2:0] addrb_c, oaddr_c;
  logic [4:0] dob_c, data_c;
  // D: 1 bank x 1, latency 1
  logic       start_d, busy_d, done_d, reb_d, valid_d, ready_d, last_d;
  logic [0:0] bankb_d, obank_d;
  logic [0:0] addrb_d, oaddr_d;
  logic [2:0] dob_d, data_d;

  mem_multi_bank_sweep_reader #(.DATA_WIDTH(3), .DEPTH(3), .NUM_BANKS(2), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done_pulse(done_a),
    .reb(reb_a), .bankb(bankb_a), .addrb(addrb_a), .dob(dob_a),
    .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a),
    .out_bank(obank_a), .out_addr(oaddr_a), .out_last(last_a));

  mem_multi_bank_sweep_reader #(.DATA_WIDTH(3), .DEPTH(3), .NUM_BANKS(2), .READ_LATENCY(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done_pulse(done_b),
    .reb(reb_b), .bankb(bankb_b), .addrb(addrb_b), .dob(dob_b),
    .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b),
    .out_bank(obank_b), .out_addr(oaddr_b), .out_last(last_b));

  mem_multi_bank_sweep_reader #(.DATA_WIDTH(5), .DEPTH(5), .NUM_BANKS(3), .READ_LATENCY(1)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .busy(busy_c), .done_pulse(done_c),
    .reb(reb_c), .bankb(bankb_c), .addrb(addrb_c), .dob(dob_c),
    .out_valid(valid_c), .out_ready(ready_c), .out_data(data_c),
    .out_bank(obank_c), .out_addr(oaddr_c), .out_last(last_c));

  mem_multi_bank_sweep_reader #(.DATA_WIDTH(3), .DEPTH(1), .NUM_BANKS(1), .READ_LATENCY(1)) dut_d (
    .clk(clk), .reset(reset), .start(start_d), .busy(busy_d), .done_pulse(done_d),
    .reb(reb_d), .bankb(bankb_d), .addrb(addrb_d), .dob(dob_d),
    .out_valid(valid_d), .out_ready(ready_d), .out_data(data_d),
    .out_bank(obank_d), .out_addr(oaddr_d), .out_last(last_d));

  // Registered-read memory models, word = {bank, addr}
  always_ff @(posedge clk) begin
    if (reb_a) dob_a <= {bankb_a, addrb_a};
    if (reb_b) b_r1 <= {bankb_b, addrb_b};
    dob_b <= b_r1;
    if (reb_c) dob_c <= {bankb_c, addrb_c};
    if (reb_d) dob_d <= {1'b1, bankb_d, addrb_d};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs A with out_ready=1 until done_pulse; optionally re-pulses start at loop index pulse_at.
  task automatic collect_a(input int pulse_at, output int done_idx);
    int  j;
    bit  seen;
    j = 0;
    seen = 0;
    done_idx = -1;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      start_a = (c == pulse_at);
      ready_a = 1'b1;
      if (valid_a) begin
        chk("a_data", data_a, (j / 3) * 4 + j % 3);
        chk("a_bank", obank_a, j / 3);
        chk("a_addr", oaddr_a, j % 3);
        chk("a_last", last_a, j == 5);
        j++;
      end
      if (done_a) begin
        seen = 1;
        done_idx = c;
      end
    end
    chk("a_beats", j, 6);
    chk("a_done_seen", seen, 1);
  endtask

  int  issued, popped, j, cnt, idx;
  bit  seen, stall, hit, exp_reb;
  logic [2:0] hd;
  logic [1:0] ha;
  logic       hb;

  initial begin
    reset = 1'b1;
    {start_a, start_b, start_c, start_d} = '0;
    {ready_a, ready_b, ready_c, ready_d} = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_busy", busy_a, 0);
    chk("rst_reb", reb_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_last", last_a, 0);
    chk("rst_addrb", {bankb_a, addrb_a}, 0);
    chk("rst_data", data_a, 0);

    // 1: basic sweep timing, ready held high
    @(negedge clk);
    start_a = 1'b1;
    ready_a = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      chk("t1_reb", reb_a, c <= 6);
      if (c <= 6) begin
        chk("t1_bankb", bankb_a, (c - 1) / 3);
        chk("t1_addrb", addrb_a, (c - 1) % 3);
      end
      chk("t1_busy", busy_a, c <= 8);
      chk("t1_done", done_a, c == 9);
      chk("t1_valid", valid_a, c >= 3 && c <= 8);
      if (c >= 3 && c <= 8) begin
        chk("t1_data", data_a, ((c - 3) / 3) * 4 + (c - 3) % 3);
        chk("t1_tag", {obank_a, oaddr_a}, ((c - 3) / 3) * 4 + (c - 3) % 3);
        chk("t1_last", last_a, c == 8);
      end
    end

    // 2: latency 2, ready toggling; bench tracks credits independently
    @(negedge clk);
    start_b = 1'b1;
    issued = 0; popped = 0; j = 0; seen = 0; stall = 0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      ready_b = (c % 2 == 1);
      exp_reb = (issued < 6) && (issued - popped < 4);
      chk("t2_reb", reb_b, exp_reb);
      if (stall) begin
        chk("t2_hold_valid", valid_b, 1);
        chk("t2_hold_data", data_b, hd);
        chk("t2_hold_tag", {obank_b, oaddr_b}, {hb, ha});
      end
      if (valid_b && ready_b) begin
        chk("t2_data", data_b, (j / 3) * 4 + j % 3);
        chk("t2_tag", {obank_b, oaddr_b}, (j / 3) * 4 + j % 3);
        chk("t2_last", last_b, j == 5);
        j++;
        popped++;
      end
      stall = valid_b && !ready_b;
      hd = data_b; ha = oaddr_b; hb = obank_b;
      if (reb_b) issued++;
      if (done_b) seen = 1;
    end
    chk("t2_beats", j, 6);
    chk("t2_done_seen", seen, 1);
    @(negedge clk);
    chk("t2_idle", busy_b, 0);

    // 3: no ready for 10 cycles, then release
    @(negedge clk);
    start_a = 1'b1;
    ready_a = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (reb_a) cnt++;
    end
    chk("t3_reb_count", cnt, 3);
    chk("t3_reb_low", reb_a, 0);
    chk("t3_valid", valid_a, 1);
    collect_a(-1, idx);

    // 5: start while busy ignored; start in done cycle accepted
    @(negedge clk);
    start_a = 1'b1;
    collect_a(3, idx);
    chk("t5_done_cycle", idx, 8);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("t5_restart_reb", reb_a, 1);
    chk("t5_restart_ptr", {bankb_a, addrb_a}, 0);
    chk("t5_restart_busy", busy_a, 1);
    collect_a(-1, idx);

    // 4: reset mid-sweep on the 7th beat, then a full sweep
    @(negedge clk);
    start_c = 1'b1;
    ready_c = 1'b1;
    j = 0; hit = 0;
    for (int c = 1; c <= 30 && !hit; c++) begin
      @(negedge clk);
      start_c = 1'b0;
      if (valid_c) begin
        chk("t4_pre_data", data_c, (j / 5) * 8 + j % 5);
        if (j == 6) hit = 1;
        j++;
      end
    end
    chk("t4_seventh", hit, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t4_busy", busy_c, 0);
    chk("t4_done", done_c, 0);
    chk("t4_reb", reb_c, 0);
    chk("t4_valid", valid_c, 0);
    chk("t4_last", last_c, 0);
    chk("t4_ptr", {bankb_c, addrb_c}, 0);
    chk("t4_data", data_c, 0);
    repeat (5) begin
      @(negedge clk);
      chk("t4_no_done", done_c, 0);
    end
    start_c = 1'b1;
    j = 0; seen = 0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge clk);
      start_c = 1'b0;
      if (valid_c) begin
        chk("t4_data2", data_c, (j / 5) * 8 + j % 5);
        chk("t4_tag2", {obank_c, oaddr_c}, (j / 5) * 8 + j % 5);
        chk("t4_last2", last_c, j == 14);
        j++;
      end
      if (done_c) seen = 1;
    end
    chk("t4_beats", j, 15);
    chk("t4_done_seen", seen, 1);

    // 6: single bank, single word
    @(negedge clk);
    start_d = 1'b1;
    ready_d = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_d = 1'b0;
      chk("t6_reb", reb_d, c == 1);
      if (c == 1) chk("t6_ptr", {bankb_d, addrb_d}, 0);
      chk("t6_valid", valid_d, c == 3);
      chk("t6_last", last_d, c == 3);
      chk("t6_done", done_d, c == 4);
      chk("t6_busy", busy_d, c <= 3);
      if (c == 3) begin
        chk("t6_data", data_d, 4);
        chk("t6_tag", {obank_d, oaddr_d}, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_multi_bank_sweep_reader.md
Name: mem_multi_bank_sweep_reader

Overview:
Read-side counterpart of the multi-bank reset-capable memory. On a start pulse it sweeps every (bank, address) pair, bank-major, through the memory's registered read port (reb/bankb/addrb -> dob). It handles the fixed read latency and returns each word with its bank/address tags on a valid/ready stream. Used for state dumps and debug readback of OPL3 operator/channel RAMs; multiple dumps may be queued back to back.

Parameters:
DATA_WIDTH, 3, word width of the swept memory
DEPTH, 3, words per bank
NUM_BANKS, 1, number of banks
BANK_WIDTH, max(1,$clog2(NUM_BANKS)), bank index width
READ_LATENCY, 1, cycles from reb to valid dob; legal values 1 or 2, equal to the memory's OUTPUT_DELAY
BUF_DEPTH, READ_LATENCY+2, output buffer entries; localparam, not overridable

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a sweep; ignored while busy
busy  out  1  high from the cycle after start is accepted until the cycle after the last beat is accepted
done_pulse  out  1  one-cycle pulse in the cycle after the final beat handshake
reb  out  1  read enable to memory
bankb  out  BANK_WIDTH  read bank to memory
addrb  out  $clog2(DEPTH)  read address to memory
dob  in  DATA_WIDTH  read data from memory, valid READ_LATENCY cycles after reb
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_data  out  DATA_WIDTH  word
out_bank  out  BANK_WIDTH  bank tag
out_addr  out  $clog2(DEPTH)  address tag
out_last  out  1  marks bank NUM_BANKS-1, addr DEPTH-1

Behaviour:
- Reset: state IDLE. Issue counters, in-flight tag pipe and buffer are cleared. busy, done_pulse, reb, out_valid and out_last are 0. bankb, addrb and out_data are 0.
- States: IDLE -> ISSUE when start=1. ISSUE -> DRAIN in the cycle after the last read is issued. DRAIN -> IDLE on the handshake of the out_last beat; done_pulse=1 in the following cycle.
- Issue rule: in ISSUE, reb=1 iff occupancy < BUF_DEPTH. Occupancy = reads in flight + entries stored; a pop in the same cycle does not free a credit. No data is ever dropped.
- Address order: addr 0..DEPTH-1 within a bank, then bank+1.
  - addr wraps to 0 at DEPTH-1, including non-power-of-2 DEPTH; address DEPTH is never issued.
  - The sweep ends after bank NUM_BANKS-1, addr DEPTH-1.
  - Exactly NUM_BANKS*DEPTH reads per sweep.
- bankb/addrb hold the current issue pointer and are only meaningful when reb=1.
- Tag pipe: a READ_LATENCY-deep shift register carries {valid, bank, addr, last} alongside each read. When the tag exits valid, dob is written into the buffer with those tags.
- Latency: start in cycle 0 -> reb first high in cycle 1 -> first out_valid in cycle 2+READ_LATENCY.
- Throughput: with out_ready held at 1, one beat per cycle.
- Backpressure: out_data and the tags stay stable while out_valid=1 and out_ready=0. Buffer order is FIFO.
- start while busy: ignored, not queued. start in the same cycle as the done_pulse cycle: accepted.
- Reset mid-sweep: immediate return to IDLE. In-flight reads are discarded and no done_pulse is produced.
- NUM_BANKS=1: bank tags are constant 0.

Decomposition:
- Package mem_sweep_pkg holds the tag struct typedef (bank, addr, last), parameterised via localparams in the instantiating module. If that is not possible, the struct is declared locally and the package holds only the state enum.
- One sub-module: sync_fifo_tagged, a BUF_DEPTH-entry synchronous FIFO with push/pop/count.
- The tag pipe reuses pipeline_sr.

Test Plan:
1. NUM_BANKS=2, DEPTH=3, READ_LATENCY=1, memory preloaded word = {bank,addr}, out_ready=1, start at cycle 0 -> reb cycles 1..6; beats cycles 3..8 in order (0,0)(0,1)(0,2)(1,0)(1,1)(1,2); out_last on the 6th beat; done_pulse cycle 9; busy cycles 1..8.
2. Same config with READ_LATENCY=2 and out_ready toggling 1,0 -> all 6 beats delivered in order; data stable across every stall; reb never raised while occupancy = 4.
3. out_ready=0 for 10 cycles after start -> reb high exactly BUF_DEPTH times, then low. Releasing out_ready delivers all beats with no loss or duplication.
4. NUM_BANKS=3, DEPTH=5, reset asserted for 1 cycle at the 7th beat -> all outputs 0 in the next cycle, no done_pulse. A new start yields a full 15-beat sweep from (0,0).
5. start re-pulsed during a sweep and again in the done_pulse cycle -> first ignored, second starts a new sweep (reb high the next cycle).
6. NUM_BANKS=1, DEPTH=1 -> a single beat with out_last=1 and bank 0, addr 0; done_pulse follows its handshake.
